rr_request_encoder: RTL
=======================

Name: rr_request_encoder

Overview:
Round-robin arbiter and encoder that sits directly upstream of the 3-to-8 line decoder. It takes 8 request lines, picks one winner fairly, and drives the decoder's Enable, A, B, C inputs. Outputs are registered. The decoder's one-hot output therefore acts as the grant vector.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles one grant may be held; used only when ARB_TIMEOUT_EN is defined; legal range 1..255.

Ports:
Clock  input  1  rising-edge clock
Resetn  input  1  asynchronous active-low reset
Req  input  8  request lines; Req[i]=1 means requester i wants the line
Enable  output  1  grant valid; drives decoder Enable
A  output  1  grant index bit 2 (MSB)
B  output  1  grant index bit 1
C  output  1  grant index bit 0 (LSB)
Busy  output  1  1 when any Req bit is set or Enable=1 (combinational OR of Req and registered Enable)

Behaviour:
- Reset (Resetn=0, asynchronous):
  - Enable=0, {A,B,C}=3'b000.
  - State=IDLE.
  - Round-robin pointer last=3'd7, so index 0 has first priority.
  - Hold counter=0.
- Grant index is {A,B,C}.
- Round-robin search:
  - Starts at (last+1) mod 8 and scans ascending with wrap to 0.
  - The first i with Req[i]=1 wins.
  - On every new grant, last<=winner.
- State IDLE (Enable=0):
  - At an edge with Req!=0: go to GRANT, Enable<=1, {A,B,C}<=winner, hold<=1.
  - Latency from request to grant is 1 clock.
  - Req==0: stay IDLE; {A,B,C} keeps its last value.
- State GRANT (Enable=1):
  - Req[{A,B,C}]=1 at the edge: keep the grant; hold saturates at 255.
  - Req[{A,B,C}]=0 at the edge (release), other Req bits set: switch directly to the next winner in the same edge with no Enable gap; hold<=1.
  - Release with Req==0: go to IDLE, Enable<=0.
- Simultaneous events:
  - Requests that rise in the same cycle as a release take part in that edge's arbitration.
  - A request that drops before it is granted is simply not considered.
- Wrap-around: last=7 starts the search at 0. A requester can win again only after every other active requester has been granted once.
- Reset mid-grant: Enable drops immediately (asynchronous) and the pointer returns to 7.
- Code changes only while Enable=1 or on the IDLE->GRANT edge, so the decoder never sees a glitch-free-but-wrong index with Enable high.

Optional Feature:
Macro: ARB_TIMEOUT_EN.
- Defined:
  - When hold==MAX_HOLD and the holder still requests, the next edge forces Enable<=0 (state IDLE) for exactly one cycle.
  - last stays at the holder's index, so on the following edge the search begins after the holder.
  - If no other requests are pending, the holder is re-granted after that one-cycle gap.
- Undefined: no counter is built and a grant is held indefinitely while its Req stays high. MAX_HOLD is ignored.

Test Plan:
1. Reset, then Req=8'b00000001 -> one clock later Enable=1, {A,B,C}=000, so the decoder output F=8'b00000001. Req=0 -> next edge Enable=0.
2. Req=8'b10000001 held for 4 grants, each holder releasing after 2 cycles and re-requesting -> grant sequence 0,7,0,7 with no Enable=0 cycles between grants.
3. Req=8'b00101100 arriving simultaneously from reset -> grants in order 2,3,5 as each releases; then Req=0 -> Enable=0 and {A,B,C} holds 101.
4. Grant active on index 6, Req=8'b01000001, assert Resetn=0 mid-cycle -> Enable=0 asynchronously. After release, Req still 8'b01000001 -> first grant is index 0.
5. With ARB_TIMEOUT_EN and MAX_HOLD=3: Req=8'b00010010 held constant -> index 1 granted for 3 cycles, 1 gap cycle, index 4 for 3 cycles, gap, index 1 again.
6. With ARB_TIMEOUT_EN and MAX_HOLD=3: Req=8'b00000100 held constant -> pattern of 3 cycles Enable=1 (code 010), 1 cycle Enable=0, repeating. Without the macro, Enable stays 1 for 20+ cycles.

Source files
------------

// File: rtl/rr_request_encoder.sv
// Round-robin arbiter over 8 request lines, driving a 3-to-8 decoder's Enable/A/B/C.
// Optional grant timeout is enabled by defining ARB_TIMEOUT_EN (uses MAX_HOLD).
module rr_request_encoder #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [7:0] Req,
  output logic       Enable,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       Busy
);

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned HOLD_W = 8;
  localparam int unsigned N_REQ  = 8;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 1..255");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   code, code_nxt;
  logic [IDX_W-1:0]   last, last_nxt;
  logic [IDX_W-1:0]   winner;
  logic               found;
  logic               any_req;
`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0]  hold, hold_nxt;
`endif

  assign any_req = |Req;

  // Scan upward from the slot after the last winner, wrapping at 7.
  always_comb begin
    winner = last;
    found  = 1'b0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      if (!found && Req[IDX_W'(last + IDX_W'(k))]) begin
        winner = IDX_W'(last + IDX_W'(k));
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      code  <= '0;
      last  <= IDX_W'(N_REQ - 1);
`ifdef ARB_TIMEOUT_EN
      hold  <= '0;
`endif
    end else begin
      state <= state_nxt;
      code  <= code_nxt;
      last  <= last_nxt;
`ifdef ARB_TIMEOUT_EN
      hold  <= hold_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    code_nxt  = code;
    last_nxt  = last;
`ifdef ARB_TIMEOUT_EN
    hold_nxt  = hold;
`endif
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = GRANT;
          code_nxt  = winner;
          last_nxt  = winner;
`ifdef ARB_TIMEOUT_EN
          hold_nxt  = HOLD_W'(1);
`endif
        end
      end
      GRANT: begin
        if (Req[code]) begin
`ifdef ARB_TIMEOUT_EN
          // Force a one-cycle gap; last stays on the holder so the next search skips it.
          if (hold == HOLD_W'(MAX_HOLD)) begin
            state_nxt = IDLE;
          end else if (hold != {HOLD_W{1'b1}}) begin
            hold_nxt = hold + HOLD_W'(1);
          end
`endif
        end else if (any_req) begin
          code_nxt = winner;
          last_nxt = winner;
`ifdef ARB_TIMEOUT_EN
          hold_nxt = HOLD_W'(1);
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Enable    = (state == GRANT);
  assign {A, B, C} = code;
  assign Busy      = any_req | Enable;

endmodule
